// File: rtl/lcd_out_ctrl.sv
// LCD timing generator and output-buffer reader.
// Emits syncs, DE and RGB565 pixels one pixel period after evaluation.
module lcd_out_ctrl #(
    parameter int H_ACT  = 480,
    parameter int H_FP   = 2,
    parameter int H_SYNC = 41,
    parameter int H_BP   = 2,
    parameter int V_ACT  = 272,
    parameter int V_FP   = 2,
    parameter int V_SYNC = 10,
    parameter int V_BP   = 2,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int X_OFF  = 80,
    parameter int Y_OFF  = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iPixEn,
    input  logic        iEnable,
    output logic        oRdEn,
    output logic [16:0] oRdAddr,
    input  logic [15:0] iRdData,
    output logic        oLcdHSync,
    output logic        oLcdVSync,
    output logic        oLcdDe,
    output logic [4:0]  oLcdR,
    output logic [5:0]  oLcdG,
    output logic [4:0]  oLcdB,
    output logic        oFrameStart
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYN_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BP + H_ACT);
    localparam logic [HW-1:0] H_IMG_BEG = HW'(H_SYNC + H_BP + X_OFF);
    localparam logic [HW-1:0] H_IMG_END = HW'(H_SYNC + H_BP + X_OFF + IMG_W);

    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYN_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BP + V_ACT);
    localparam logic [VW-1:0] V_IMG_BEG = VW'(V_SYNC + V_BP + Y_OFF);
    localparam logic [VW-1:0] V_IMG_END = VW'(V_SYNC + V_BP + Y_OFF + IMG_H);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [16:0] addr_cnt;

    logic        pend_hs;
    logic        pend_vs;
    logic        pend_de;
    logic        pend_img;
    logic        rd_vld;
    logic [15:0] pix_q;

    logic        h_end;
    logic        at_last;
    logic        origin;
    logic        ev_hs;
    logic        ev_vs;
    logic        ev_de;
    logic        in_img;
    logic        eval;
    logic [15:0] pix;

    always_comb begin
        h_end   = (hcnt == H_LAST);
        at_last = h_end && (vcnt == V_LAST);
        origin  = (hcnt == '0) && (vcnt == '0);
        ev_hs   = (hcnt >= H_SYN_END);
        ev_vs   = (vcnt >= V_SYN_END);
        ev_de   = (hcnt >= H_ACT_BEG) && (hcnt < H_ACT_END)
               && (vcnt >= V_ACT_BEG) && (vcnt < V_ACT_END);
        in_img  = ev_de
               && (hcnt >= H_IMG_BEG) && (hcnt < H_IMG_END)
               && (vcnt >= V_IMG_BEG) && (vcnt < V_IMG_END);
        eval    = 1'b0;
        unique case (state)
            IDLE: eval = iPixEn && iEnable;
            RUN:  eval = iPixEn;
        endcase
        // Read data may land on the very cycle of the next strobe.
        pix = rd_vld ? iRdData : pix_q;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            addr_cnt    <= '0;
            pend_hs     <= 1'b1;
            pend_vs     <= 1'b1;
            pend_de     <= 1'b0;
            pend_img    <= 1'b0;
            rd_vld      <= 1'b0;
            pix_q       <= '0;
            oRdEn       <= 1'b0;
            oRdAddr     <= '0;
            oLcdHSync   <= 1'b1;
            oLcdVSync   <= 1'b1;
            oLcdDe      <= 1'b0;
            oLcdR       <= '0;
            oLcdG       <= '0;
            oLcdB       <= '0;
            oFrameStart <= 1'b0;
        end else begin
            oRdEn       <= 1'b0;
            oFrameStart <= 1'b0;
            rd_vld      <= oRdEn;
            if (rd_vld) begin
                pix_q <= iRdData;
            end

            if (iPixEn) begin
                oLcdHSync <= pend_hs;
                oLcdVSync <= pend_vs;
                oLcdDe    <= pend_de;
                oLcdR     <= pend_img ? pix[15:11] : '0;
                oLcdG     <= pend_img ? pix[10:5]  : '0;
                oLcdB     <= pend_img ? pix[4:0]   : '0;
            end

            if (eval) begin
                pend_hs  <= ev_hs;
                pend_vs  <= ev_vs;
                pend_de  <= ev_de;
                pend_img <= in_img;
                if (origin) begin
                    oFrameStart <= 1'b1;
                    addr_cnt    <= '0;
                end else if (in_img) begin
                    oRdEn    <= 1'b1;
                    oRdAddr  <= addr_cnt;
                    addr_cnt <= addr_cnt + 17'd1;
                end
                hcnt <= h_end ? '0 : hcnt + 1'b1;
                if (h_end) begin
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                end
                state <= (at_last && !iEnable) ? IDLE : RUN;
            end else if (iPixEn) begin
                pend_hs  <= 1'b1;
                pend_vs  <= 1'b1;
                pend_de  <= 1'b0;
                pend_img <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_out_ctrl.sv
// Directed bench for lcd_out_ctrl on a reduced 15x10 timing grid.
// Image 4x3 at active (2,1); active area 8x6 starting at (5,3).
module tb_lcd_out_ctrl;

    localparam int HT    = 15;
    localparam int FRAME = 150;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic        en;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [15:0] rd_data;
    logic        hs;
    logic        vs;
    logic        de;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic        fs;

    lcd_out_ctrl #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .IMG_W(4), .IMG_H(3), .X_OFF(2), .Y_OFF(1)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .iPixEn(pix_en),
        .iEnable(en),
        .oRdEn(rd_en),
        .oRdAddr(rd_addr),
        .iRdData(rd_data),
        .oLcdHSync(hs),
        .oLcdVSync(vs),
        .oLcdDe(de),
        .oLcdR(r),
        .oLcdG(g),
        .oLcdB(b),
        .oFrameStart(fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic ram_mode;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= ram_mode ? rd_addr[15:0] : 16'hF800;
        end
    end

    int n_chk;
    int n_pass;
    int rd_cnt, fs_cnt, first_addr, last_addr, order_err;
    int hs_low, vs_low, de_cnt, de_err, red_cnt, stray, pix_err;
    int first_rd_k, drop_k, idle_act;

    always @(posedge clk) begin
        #1;
        if (rd_en) begin
            if (rd_cnt > 0 && int'(rd_addr) <= last_addr) order_err++;
            if (rd_cnt == 0) first_addr = int'(rd_addr);
            last_addr = int'(rd_addr);
            rd_cnt++;
        end
        if (fs) fs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_stats();
        rd_cnt = 0; fs_cnt = 0; first_addr = -1; last_addr = -1;
        order_err = 0; hs_low = 0; vs_low = 0; de_cnt = 0; de_err = 0;
        red_cnt = 0; stray = 0; pix_err = 0; first_rd_k = -1;
        drop_k = -1; idle_act = 0;
    endtask

    task automatic pix_strobe();
        @(negedge clk); pix_en = 1'b1;
        @(negedge clk); pix_en = 1'b0;
    endtask

    task automatic run_frame(input int n);
        int p, hp, vp;
        logic img, act;
        logic [15:0] rgb;
        for (int k = 0; k < n; k++) begin
            if (k == drop_k) en = 1'b0;
            pix_strobe();
            if (rd_en && first_rd_k < 0) first_rd_k = k;
            if (k > 0) begin
                p   = k - 1;
                hp  = p % HT;
                vp  = p / HT;
                act = hp >= 5 && hp < 13 && vp >= 3 && vp < 9;
                img = hp >= 7 && hp < 11 && vp >= 4 && vp < 7;
                rgb = {r, g, b};
                if (!hs) hs_low++;
                if (!vs) vs_low++;
                if (de) de_cnt++;
                if (de !== act) de_err++;
                if (!img && rgb != 16'h0) stray++;
                if (img && rgb == 16'hF800) red_cnt++;
                if (img && rgb != 16'((vp - 4) * 4 + (hp - 7))) pix_err++;
            end
        end
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) begin
            pix_strobe();
            if (!hs || !vs || de || {r, g, b} != 16'h0) idle_act++;
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; pix_en = 1'b0; en = 1'b0; ram_mode = 1'b0;
        rd_data = 16'h0;
        clear_stats();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_syncs_de", {29'd0, hs, vs, de}, 32'd6);
        check("rst_rgb", {16'd0, r, g, b}, 32'd0);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_rd_addr", {15'd0, rd_addr}, 32'd0);
        check("rst_fs", {31'd0, fs}, 32'd0);

        clear_stats();
        run_idle(4);
        check("idle_fs", fs_cnt, 0);
        check("idle_rd", rd_cnt, 0);
        check("idle_outs", idle_act, 0);

        clear_stats();
        en = 1'b1;
        run_frame(FRAME);
        check("f1_fs", fs_cnt, 1);
        check("f1_rd_cnt", rd_cnt, 12);
        check("f1_first_addr", first_addr, 0);
        check("f1_last_addr", last_addr, 11);
        check("f1_order", order_err, 0);
        check("f1_first_rd_k", first_rd_k, 67);
        check("f1_hs_low", hs_low, 30);
        check("f1_vs_low", vs_low, 30);
        check("f1_de_cnt", de_cnt, 48);
        check("f1_de_err", de_err, 0);
        check("f1_red", red_cnt, 12);
        check("f1_stray", stray, 0);

        clear_stats();
        ram_mode = 1'b1;
        drop_k = 75;
        run_frame(FRAME);
        check("f2_fs", fs_cnt, 1);
        check("f2_rd_cnt", rd_cnt, 12);
        check("f2_first_addr", first_addr, 0);
        check("f2_last_addr", last_addr, 11);
        check("f2_order", order_err, 0);
        check("f2_pix", pix_err, 0);
        check("f2_stray", stray, 0);
        check("f2_hs_low", hs_low, 30);
        check("f2_de_cnt", de_cnt, 48);
        run_idle(6);
        check("drop_rd_cnt", rd_cnt, 12);
        check("drop_fs", fs_cnt, 1);
        check("drop_idle_outs", idle_act, 0);

        clear_stats();
        en = 1'b1;
        run_frame(84);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mrst_syncs_de", {29'd0, hs, vs, de}, 32'd6);
        check("mrst_rgb", {16'd0, r, g, b}, 32'd0);
        check("mrst_rd_en", {31'd0, rd_en}, 32'd0);
        check("mrst_rd_addr", {15'd0, rd_addr}, 32'd0);

        clear_stats();
        run_frame(FRAME);
        check("mrst_fs", fs_cnt, 1);
        check("mrst_first_addr", first_addr, 0);
        check("mrst_first_rd_k", first_rd_k, 67);
        check("mrst_rd_cnt", rd_cnt, 12);
        check("mrst_pix", pix_err, 0);

        clear_stats();
        @(negedge clk); rst = 1'b1; pix_en = 1'b1;
        @(negedge clk); rst = 1'b0; pix_en = 1'b0;
        repeat (3) @(negedge clk);
        check("coll_fs", fs_cnt, 0);
        check("coll_rd", rd_cnt, 0);
        run_frame(68);
        check("coll_restart_fs", fs_cnt, 1);
        check("coll_first_rd_k", first_rd_k, 67);
        check("coll_first_addr", first_addr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_out_ctrl.md
LCD_OUT_CTRL -- requirements
Module: lcd_out_ctrl

Interface
REQ-001 Parameter H_ACT, 480, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 2 / 41 / 2, horizontal front porch, sync width and back porch in pixels.
REQ-003 Parameter V_ACT, 272, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 2 / 10 / 2, vertical front porch, sync width and back porch in lines.
REQ-005 Parameter IMG_W / IMG_H, 320 / 240, source image size in the output buffer.
REQ-006 Parameter X_OFF / Y_OFF, 80 / 16, image position inside the active area.
REQ-007 iClk  in  1  single system clock (100 MHz); all logic SHALL be clocked on its rising edge.
REQ-008 iRst  in  1  synchronous, active-high reset.
REQ-009 iPixEn  in  1  one-iClk strobe per LCD pixel; consecutive strobes SHALL be at least 2 iClk apart.
REQ-010 iEnable  in  1  level; display runs while high.
REQ-011 oRdEn  out  1  output-buffer read strobe.
REQ-012 oRdAddr  out  17  output-buffer read address.
REQ-013 iRdData  in  16  RGB565 read data, valid in the iClk cycle after oRdEn.
REQ-014 oLcdHSync / oLcdVSync  out  1 each  active-low syncs.
REQ-015 oLcdDe  out  1  active-area flag.
REQ-016 oLcdR / oLcdG / oLcdB  out  5 / 6 / 5  pixel colour.
REQ-017 oFrameStart  out  1  one-iClk pulse at frame origin.

Function
REQ-018 Horizontal counter: range 0..H_TOTAL-1 with H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP (525); vertical counter: range 0..V_TOTAL-1 with V_TOTAL = 286. Both SHALL advance only on iPixEn; vcnt SHALL increment when hcnt wraps; both SHALL wrap to 0 after the last pixel.
REQ-019 Raw sync: hsync = 0 when hcnt < H_SYNC; vsync = 0 when vcnt < V_SYNC.
REQ-020 Active area: H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACT, with the same rule on vcnt. Image region: active area and x in [X_OFF, X_OFF+IMG_W), y in [Y_OFF, Y_OFF+IMG_H), where x and y are active-relative coordinates.
REQ-021 FSM states: IDLE and RUN. Reset state is IDLE.
REQ-022 IDLE: counters held at 0; outputs held at their reset values.
REQ-023 IDLE->RUN on an iPixEn cycle with iEnable=1; that cycle evaluates position (0,0).
REQ-024 RUN->IDLE only on the iPixEn cycle that evaluates the last position (H_TOTAL-1, V_TOTAL-1) while iEnable=0. Deasserting iEnable mid-frame SHALL NOT truncate the frame.
REQ-025 On each RUN iPixEn cycle with position in the image region: oRdEn=1 for exactly the next iClk cycle, with oRdAddr = current image address. Otherwise oRdEn=0.
REQ-026 Address generation: row-major y_img*IMG_W + x_img, produced by an incrementing counter (no multiplier). The counter SHALL reset to 0 at frame origin and SHALL advance once per image pixel. The final address is 76799; no wrap within a frame.
REQ-027 Pipeline: the iPixEn following the evaluation of position P SHALL register P's hsync, vsync and DE onto the outputs.
REQ-028 On that same iPixEn, RGB outputs SHALL be set as follows: if P is in the image region, R = iRdData[15:11], G = iRdData[10:5], B = iRdData[4:0] (data captured the cycle after oRdEn); otherwise 0. Output latency is exactly one pixel period, with syncs and data aligned.
REQ-029 Outputs SHALL hold their values between iPixEn strobes.
REQ-030 oFrameStart=1 for one iClk cycle following the RUN iPixEn cycle that evaluates (0,0).
REQ-031 iPixEn asserted in the same cycle as iRst SHALL be ignored.

Reset
REQ-032 When iRst=1, on the next edge: state = IDLE, counters = 0, address counter = 0, oLcdHSync = 1, oLcdVSync = 1, oLcdDe = 0, RGB = 0, oRdEn = 0, oRdAddr = 0, oFrameStart = 0.
REQ-033 Reset SHALL take priority over all other inputs, including in mid-frame. After reset release, the block SHALL restart from (0,0) only per REQ-023.

Verification
REQ-034 Reset with iPixEn every 4 iClk, then iEnable=1 -> oFrameStart pulses once per 525*286 = 150150 strobes; oLcdHSync low for 41 strobes per line; oLcdVSync low for 10 lines.
REQ-035 Buffer model returns 16'hF800 at every address -> oLcdR = 5'h1F and G = B = 0 inside the image region only; region spans 320x240 starting at active (80,16); black elsewhere; DE high for 480x272 per frame.
REQ-036 Buffer model returns data = address[15:0] -> exactly 76800 oRdEn pulses per frame, with addresses 0..76799 strictly increasing; each pixel appears one strobe after its read; first read occurs at hcnt = 43+80, vcnt = 12+16.
REQ-037 iEnable dropped at mid-frame (vcnt = 100) -> frame completes through (524, 285), then IDLE; syncs stay high; no further oRdEn.
REQ-038 iRst=1 pulse at hcnt = 200, vcnt = 50 -> next cycle all outputs at reset values; with iEnable still high, the next frame starts at (0,0) with address 0.
REQ-039 iPixEn and iRst asserted in the same cycle -> counters remain at 0 and no oRdEn is issued.
